// File: rtl/fetch_stage_pkg.sv
// Shared widths and FSM encoding for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned ISIZE   = 16;
    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2,
        StDrop = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; priority is flush > stall > load > bubble.
module ifid_reg #(
    parameter int unsigned IW = 32,
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          stall,
    input  logic          load,
    input  logic [IW-1:0] load_instr,
    input  logic [AW-1:0] load_pc,
    output logic          valid,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] pc
);

    logic          valid_q;
    logic [IW-1:0] instr_q;
    logic [AW-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                valid_q <= 1'b1;
                instr_q <= load_instr;
                pc_q    <= load_pc;
            end else begin
                // Bubble: payload is left as-is, only the valid bit drops.
                valid_q <= 1'b0;
            end
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem requests, hold buffer for stalled
// responses, squash of in-flight responses on redirect, and the nextPC steering mux.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned IW = INSTR_W,
    parameter int unsigned AW = ISIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] currPC,
    output logic [AW-1:0] nextPC,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rvalid,
    input  logic [IW-1:0] imem_rdata,
    input  logic          stall,
    input  logic          flush,
    input  logic [AW-1:0] branch_target,
    output logic          ifid_valid,
    output logic [IW-1:0] ifid_instr,
    output logic [AW-1:0] ifid_pc
);

    localparam logic [AW-1:0] PcOne = AW'(1);

    fetch_state_e state_q, state_d;

    logic [AW-1:0] req_pc_q;
    logic [IW-1:0] hold_instr_q;
    logic [AW-1:0] hold_pc_q;
    logic          hold_capture;

    logic          ifid_load;
    logic [IW-1:0] ifid_load_instr;
    logic [AW-1:0] ifid_load_pc;

    logic [AW-1:0] pc_hold;
    logic [AW-1:0] pc_advance;
    logic [AW-1:0] pc_redirect;
    logic [AW-1:0] next_pc;

    // The PC register adds one to whatever we drive, so each choice is pre-decremented.
    assign pc_hold     = currPC - PcOne;
    assign pc_advance  = currPC;
    assign pc_redirect = branch_target - PcOne;

    always_comb begin
        state_d         = state_q;
        next_pc         = pc_hold;
        imem_req        = 1'b0;
        imem_addr       = currPC;
        hold_capture    = 1'b0;
        ifid_load       = 1'b0;
        ifid_load_instr = imem_rdata;
        ifid_load_pc    = req_pc_q;

        unique case (state_q)
            StReq: begin
                imem_req = 1'b1;
                if (flush) begin
                    next_pc = pc_redirect;
                    state_d = StDrop;
                end else begin
                    state_d = StWait;
                end
            end

            StWait: begin
                if (flush) begin
                    next_pc = pc_redirect;
                    state_d = imem_rvalid ? StReq : StDrop;
                end else if (imem_rvalid) begin
                    if (!stall) begin
                        ifid_load = 1'b1;
                        next_pc   = pc_advance;
                        state_d   = StReq;
                    end else begin
                        hold_capture = 1'b1;
                        state_d      = StHold;
                    end
                end
            end

            StHold: begin
                ifid_load_instr = hold_instr_q;
                ifid_load_pc    = hold_pc_q;
                if (flush) begin
                    next_pc = pc_redirect;
                    state_d = StReq;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    next_pc   = pc_advance;
                    state_d   = StReq;
                end
            end

            StDrop: begin
                if (flush) begin
                    next_pc = pc_redirect;
                end
                // A response coinciding with a repeat flush is still the squashed one.
                if (imem_rvalid) begin
                    state_d = StReq;
                end
            end

            default: begin
                state_d = StReq;
            end
        endcase

        if (rst) begin
            imem_req     = 1'b0;
            hold_capture = 1'b0;
            ifid_load    = 1'b0;
            state_d      = StReq;
        end
    end

    assign nextPC = next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_pc_q <= '0;
        end else if (state_q == StReq) begin
            req_pc_q <= currPC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else if (hold_capture) begin
            hold_instr_q <= imem_rdata;
            hold_pc_q    <= req_pc_q;
        end
    end

    ifid_reg #(
        .IW(IW),
        .AW(AW)
    ) u_ifid_reg (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .stall      (stall),
        .load       (ifid_load),
        .load_instr (ifid_load_instr),
        .load_pc    (ifid_load_pc),
        .valid      (ifid_valid),
        .instr      (ifid_instr),
        .pc         (ifid_pc)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a PC register and variable-latency memory model.
module tb_fetch_stage;

    localparam int AW = 16;
    localparam int IW = 32;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] currPC;
    logic [AW-1:0] nextPC;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          stall;
    logic          flush;
    logic [AW-1:0] branch_target;
    logic          ifid_valid;
    logic [IW-1:0] ifid_instr;
    logic [AW-1:0] ifid_pc;

    int vectors     = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    int            mem_lat = 1;
    logic          mem_pend;
    int            mem_cnt;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] last_addr;
    int            req_cnt = 0;
    logic          stall_q;

    fetch_stage #(
        .IW(IW),
        .AW(AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .currPC        (currPC),
        .nextPC        (nextPC),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .flush         (flush),
        .branch_target (branch_target),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    // PC register: loads nextPC + 1.
    always @(posedge clk) begin
        if (rst) currPC <= '0;
        else     currPC <= nextPC + 16'd1;
    end

    // Instruction memory: response mem_lat cycles after the sampled request.
    always @(posedge clk) begin
        if (rst) begin
            mem_pend    <= 1'b0;
            imem_rvalid <= 1'b0;
        end else begin
            imem_rvalid <= 1'b0;
            if (mem_pend) begin
                if (mem_cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= instr_of(mem_addr);
                    mem_pend    <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
            if (imem_req) begin
                req_cnt   <= req_cnt + 1;
                last_addr <= imem_addr;
                if (mem_lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= instr_of(imem_addr);
                end else begin
                    mem_pend <= 1'b1;
                    mem_cnt  <= mem_lat - 1;
                    mem_addr <= imem_addr;
                end
            end
        end
    end

    always @(posedge clk) stall_q <= stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a fresh IF/ID word is one that is valid after an edge with stall low.
    always @(negedge clk) begin
        if (ifid_valid === 1'b1 && stall_q === 1'b0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL ifid_unexpected: got pc %0h instr %0h expected nothing",
                         ifid_pc, ifid_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ifid_word", {16'h0, ifid_pc, ifid_instr}, {16'h0, e.pc, e.instr});
            end
        end
    end

    task automatic push(input logic [AW-1:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = instr_of(a);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int lat);
        rst           = 1'b1;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_target = '0;
        mem_lat       = lat;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget, output int cyc);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            step();
            cyc++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int r0;

        // Reset state.
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0; mem_lat = 1;
        step();
        step();
        check("rst_ifid_valid", ifid_valid, 0);
        check("rst_ifid_instr", ifid_instr, 0);
        check("rst_ifid_pc", ifid_pc, 0);
        check("rst_imem_req", imem_req, 0);

        // Streaming with single-cycle memory.
        rst = 1'b0;
        #1;
        check("p1_hold_at_zero", nextPC, 16'hFFFF);
        check("p1_req", imem_req, 1);
        check("p1_addr", imem_addr, 0);
        for (int a = 0; a < 4; a++) push(16'(a));
        wait_drain("p1_drain", 40, cyc);
        check("p1_cycles", cyc, 8);

        // Stall across the pc 2 response.
        do_reset(1);
        for (int a = 0; a < 3; a++) push(16'(a));
        repeat (5) step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("p2_hold_pc", ifid_pc, 1);
            check("p2_no_req", imem_req, 0);
            check("p2_pc_hold", nextPC, 1);
        end
        stall = 1'b0;
        wait_drain("p2_drain", 40, cyc);

        // Flush in WAIT with no response: late response squashed.
        do_reset(3);
        r0 = req_cnt;
        push(16'h0040);
        step();
        check("p3_wait_no_req", imem_req, 0);
        flush = 1'b1;
        branch_target = 16'h0040;
        #1;
        check("p3_redirect", nextPC, 16'h003F);
        step();
        flush = 1'b0;
        check("p3_curr_pc", currPC, 16'h0040);
        check("p3_drop_no_req", imem_req, 0);
        wait_drain("p3_drain", 40, cyc);
        check("p3_last_addr", last_addr, 16'h0040);
        check("p3_req_count", req_cnt - r0, 2);

        // Flush beats stall with a live IF/ID entry.
        do_reset(1);
        push(16'h0000);
        push(16'h0080);
        step();
        step();
        check("p4_pre_valid", ifid_valid, 1);
        stall = 1'b1;
        flush = 1'b1;
        branch_target = 16'h0080;
        step();
        check("p4_flush_clears", ifid_valid, 0);
        check("p4_curr_pc", currPC, 16'h0080);
        stall = 1'b0;
        flush = 1'b0;
        wait_drain("p4_drain", 40, cyc);

        // Wrap at 0xFFFF and redirect to 0.
        do_reset(1);
        flush = 1'b1;
        branch_target = 16'hFFFF;
        #1;
        check("p5_redirect_ffff", nextPC, 16'hFFFE);
        push(16'hFFFF);
        push(16'h0000);
        push(16'h0001);
        step();
        flush = 1'b0;
        check("p5_curr_ffff", currPC, 16'hFFFF);
        wait_drain("p5_drain", 40, cyc);
        flush = 1'b1;
        branch_target = 16'h0000;
        #1;
        check("p5_target_zero", nextPC, 16'hFFFF);
        step();
        flush = 1'b0;
        check("p5_curr_zero", currPC, 16'h0000);

        // Four-cycle memory: one request per instruction, PC held in WAIT.
        do_reset(4);
        r0 = req_cnt;
        for (int a = 0; a < 3; a++) push(16'(a));
        step();
        step();
        check("p6_wait_pc", currPC, 0);
        check("p6_wait_next", nextPC, 16'hFFFF);
        check("p6_wait_no_req", imem_req, 0);
        step();
        check("p6_wait_pc2", currPC, 0);
        wait_drain("p6_drain", 60, cyc);
        check("p6_req_count", req_cnt - r0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage directly downstream of the program-counter register in the three-stage pipeline. It consumes `currPC`, issues one request at a time to instruction memory, and loads the returned word into the IF/ID pipeline register for decode. It drives `nextPC` back to the PC register, which loads `nextPC + 1` each cycle, so that register holds, advances or redirects. It also handles decode stalls, branch flushes and squashing of an in-flight memory response.

## Interface
- `IW`, default 32: instruction word width.
- `AW`, default `` `ISIZE `` (16, from define.v): instruction address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `currPC` in AW: current PC from the PC register.
- `nextPC` out AW: combinational; the PC register loads `nextPC + 1`.
- `imem_req` out 1: request strobe, high for exactly one cycle per request.
- `imem_addr` out AW: request address, valid while `imem_req` is high.
- `imem_rvalid` in 1: one-cycle pulse carrying the response to the single outstanding request; latency ≥ 1 cycle.
- `imem_rdata` in IW: instruction word, valid while `imem_rvalid` is high.
- `stall` in 1: decode cannot accept; IF/ID must hold.
- `flush` in 1: branch redirect request.
- `branch_target` in AW: redirect address, valid while `flush` is high.
- `ifid_valid` out 1: registered; IF/ID holds a live instruction.
- `ifid_instr` out IW: registered instruction word.
- `ifid_pc` out AW: registered address of `ifid_instr`.

## Operation
- PC control, all arithmetic mod 2^AW (wrap is intentional):
  - hold: `nextPC = currPC - 1`
  - advance: `nextPC = currPC`
  - redirect: `nextPC = branch_target - 1`
  - At `currPC = 0`, hold drives `nextPC = 2^AW - 1`.
  - `branch_target = 0` drives `nextPC = 2^AW - 1`.
- Default in every state is hold. Only "advance" and "redirect" below change the PC.
- FSM states are REQ, WAIT, HOLD and DROP. Reset state is REQ.
- REQ:
  - Drive `imem_req = 1`, `imem_addr = currPC`, and capture `currPC` into `req_pc`.
  - `flush`: redirect, go to DROP.
  - Otherwise go to WAIT.
- WAIT:
  - `flush & imem_rvalid`: discard the data, redirect, go to REQ.
  - `flush & !imem_rvalid`: redirect, go to DROP.
  - `imem_rvalid & !stall`: load IF/ID with {`imem_rdata`, `req_pc`}, advance, go to REQ.
  - `imem_rvalid & stall`: capture {`imem_rdata`, `req_pc`} into the hold buffer, go to HOLD.
- HOLD:
  - `flush`: discard the buffer, redirect, go to REQ.
  - `!stall`: load IF/ID from the buffer, advance, go to REQ.
- DROP:
  - Wait for `imem_rvalid`, discard it, go to REQ.
  - `flush` while in DROP: redirect again and stay in DROP.
- IF/ID register priority: `flush` > `stall` > load > bubble.
  - `flush`: clears `ifid_valid`.
  - `stall`: holds all three fields.
  - Load: sets `ifid_valid = 1`.
  - Bubble (no stall, no new instruction): `ifid_valid = 0`, `ifid_instr` and `ifid_pc` unchanged.
- At most one request is outstanding. `imem_req` is never high outside REQ.

## Timing
- Reset values:
  - `ifid_valid = 0`, `ifid_instr = 0`, `ifid_pc = 0`.
  - `imem_req = 0` and FSM forced to REQ while `rst` is high.
  - `nextPC` is don't-care during reset; the PC register's own reset wins.
- Reset mid-operation: any in-flight response arriving after reset deasserts is treated as a fresh WAIT response. Memory is reset together with this block.
- With single-cycle memory (rvalid one cycle after req):
  - Request at t, IF/ID valid at t+2, next request at t+2 with `currPC + 1`.
  - Sustained throughput is 1 instruction per 2 cycles.
- Redirect on cycle t: `currPC = branch_target` from t+1; the first request to the target goes out once the FSM reaches REQ.

## Structure
- Put the FSM state encoding (2-bit localparams) and `IW` in the shared define/package next to `` `ISIZE ``.
- One sub-module is natural: `ifid_reg`, the IF/ID register with valid/stall/flush priority. The FSM, hold buffer and `nextPC` mux stay in `fetch_stage`.

## Test plan
- Reset, then memory returning `I(a) = 0x1000_0000 + a` after 1 cycle → IF/ID shows pc 0, 1, 2, 3 with matching instr, `ifid_valid` high every other cycle.
- `stall` high for 3 cycles covering the rvalid for pc 2 → word held in HOLD; IF/ID keeps pc 1 during the stall, then shows pc 2 after release; no request issued while in HOLD.
- `flush` with target 0x0040 in WAIT with no rvalid → DROP; a late rvalid is discarded; the next request goes to 0x0040 and IF/ID never shows the squashed word.
- `flush` coincident with `stall` and `ifid_valid = 1` → `ifid_valid` = 0 next cycle.
- PC at 0xFFFF advancing → next fetch at 0x0000; `branch_target = 0` → `nextPC = 0xFFFF`, `currPC` becomes 0.
- Memory latency 4 cycles → exactly one `imem_req` per instruction; PC holds throughout WAIT.
